axo_mem_arbiter: RTL

AXO_MEM_ARBITER -- requirements
Module: axo_mem_arbiter

---
 rtl/axo_mem_pkg.sv | 13 +
 rtl/axo_mem_bus.sv | 17 +
 rtl/axo_rr_pick.sv | 33 +++
 rtl/axo_mem_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/axo_mem_pkg.sv
// rtl/axo_mem_pkg.sv - shared memory-bus types and arbiter state encoding
package axo_mem_pkg;

  localparam int ASIZE_W = 2;

  typedef logic [ASIZE_W-1:0] asize_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/axo_mem_bus.sv
// rtl/axo_mem_bus.sv - simple request/ready memory bus shared by requesters and memory
interface axo_mem_bus #(
  parameter int dlen = 32,
  parameter int alen = 32
);
  logic                  re;
  logic                  we;
  axo_mem_pkg::asize_t   asize;
  logic [alen-1:0]       addr;
  logic [dlen-1:0]       wdata;
  logic [dlen-1:0]       rdata;
  logic                  ready;
  logic                  error;

  modport master (output re, we, asize, addr, wdata, input rdata, ready, error);
  modport slave  (input re, we, asize, addr, wdata, output rdata, ready, error);
endinterface

// File: rtl/axo_rr_pick.sv
// rtl/axo_rr_pick.sv - combinational rotating-priority search starting at ptr_i
module axo_rr_pick #(
  parameter int n = 4,
  localparam int IW = $clog2(n)
) (
  input  logic [n-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  typedef logic [IW:0] sum_t;

  sum_t slot;

  // Walk the offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    slot    = '0;
    for (int k = n - 1; k >= 0; k--) begin
      slot = sum_t'(ptr_i) + sum_t'(k);
      if (slot >= sum_t'(n)) begin
        slot = slot - sum_t'(n);
      end
      if (req_i[slot[IW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = slot[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/axo_mem_arbiter.sv
// rtl/axo_mem_arbiter.sv - round-robin arbiter granting one requester bus at a time to memory
module axo_mem_arbiter
  import axo_mem_pkg::*;
#(
  parameter int dlen = 32,
  parameter int alen = 32,
  parameter int cpus = 4
) (
  input  logic        clk,
  input  logic        rst,
  axo_mem_bus.slave   cpu_bus [cpus],
  axo_mem_bus.master  mem_bus
);

  localparam int IW = $clog2(cpus);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_next;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic            busy;

  logic [cpus-1:0] req;
  logic [cpus-1:0] re_a;
  logic [cpus-1:0] we_a;
  logic [cpus-1:0] sel;
  asize_t          asize_a [cpus];
  logic [alen-1:0] addr_a  [cpus];
  logic [dlen-1:0] wdata_a [cpus];

  assign busy = (state_q == BUSY);

  for (genvar g = 0; g < cpus; g++) begin : g_cpu
    assign re_a[g]    = cpu_bus[g].re;
    assign we_a[g]    = cpu_bus[g].we;
    assign asize_a[g] = cpu_bus[g].asize;
    assign addr_a[g]  = cpu_bus[g].addr;
    assign wdata_a[g] = cpu_bus[g].wdata;
    assign req[g]     = re_a[g] | we_a[g];

    // Only the current owner ever sees the memory response.
    assign sel[g]           = busy && (owner_q == IW'(g));
    assign cpu_bus[g].ready = sel[g] & mem_bus.ready;
    assign cpu_bus[g].error = sel[g] & mem_bus.error;
    assign cpu_bus[g].rdata = sel[g] ? mem_bus.rdata : '0;
  end

  assign mem_bus.re    = busy & re_a[owner_q];
  assign mem_bus.we    = busy & we_a[owner_q];
  assign mem_bus.asize = busy ? asize_a[owner_q] : '0;
  assign mem_bus.addr  = busy ? addr_a[owner_q]  : '0;
  assign mem_bus.wdata = busy ? wdata_a[owner_q] : '0;

  assign owner_next = (owner_q == IW'(cpus - 1)) ? '0 : owner_q + IW'(1);

  axo_rr_pick #(
    .n (cpus)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          owner_d = pick_idx;
        end
      end
      BUSY: begin
        // Completion and an abandoned request both release the bus the same way.
        if (!req[owner_q] || mem_bus.ready) begin
          state_d = IDLE;
          ptr_d   = owner_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule
